// File: rtl/sie_defs_pkg.sv
// Shared USB SIE definitions: transmit FSM states, bus line states and their
// D+/D- drive encodings, plus the command set of the NRZI/stuffing encoder.
package sie_defs_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SYNC,
    TX_DATA,
    TX_EOP_SE0,
    TX_EOP_J
  } tx_state_t;

  typedef enum logic [1:0] {
    LINE_J,
    LINE_K,
    LINE_SE0
  } line_state_t;

  // {P, N} drive values for each full-speed line state
  localparam logic [1:0] PN_J   = 2'b10;
  localparam logic [1:0] PN_K   = 2'b01;
  localparam logic [1:0] PN_SE0 = 2'b00;

  localparam logic [1:0] ENC_DATA = 2'd0;
  localparam logic [1:0] ENC_SE0  = 2'd1;
  localparam logic [1:0] ENC_J    = 2'd2;

  function automatic logic [1:0] line_pn(input line_state_t ls);
    case (ls)
      LINE_J:   line_pn = PN_J;
      LINE_K:   line_pn = PN_K;
      LINE_SE0: line_pn = PN_SE0;
      default:  line_pn = PN_J;
    endcase
  endfunction

endpackage

// File: rtl/usb_nrzi_stuff_enc.sv
// Per-bit NRZI encoder with bit stuffing: on each strobe drives the next line
// level for bit_in, or a stuffed 0 when enough consecutive 1s have gone out.
module usb_nrzi_stuff_enc
  import sie_defs_pkg::*;
#(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       strobe,
  input  logic [1:0] cmd,
  input  logic       bit_in,
  output logic       stuff_pending,
  output logic       dataOutP,
  output logic       dataOutN
);

  localparam int OW = $clog2(STUFF_LEN + 1);

  logic [1:0]    pn_q, pn_d;
  logic [OW-1:0] ones_q, ones_d;
  logic [1:0]    toggled_s;

  assign stuff_pending = (ones_q == OW'(STUFF_LEN));
  assign toggled_s     = (pn_q == line_pn(LINE_K)) ? line_pn(LINE_J) : line_pn(LINE_K);
  assign dataOutP      = pn_q[1];
  assign dataOutN      = pn_q[0];

  // Next line level and run-length of 1s
  always_comb begin
    pn_d   = pn_q;
    ones_d = ones_q;
    if (strobe) begin
      case (cmd)
        ENC_SE0: begin
          pn_d   = line_pn(LINE_SE0);
          ones_d = OW'(0);
        end
        ENC_J: begin
          pn_d   = line_pn(LINE_J);
          ones_d = OW'(0);
        end
        default: begin
          // A stuffed bit is a 0, so it toggles exactly like a data 0
          if (stuff_pending || !bit_in) begin
            pn_d   = toggled_s;
            ones_d = OW'(0);
          end else begin
            ones_d = ones_q + OW'(1);
          end
        end
      endcase
    end else begin
      pn_d = pn_q;
    end
  end

  // Line level and ones-counter registers
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      pn_q   <= PN_J;
      ones_q <= OW'(0);
    end else begin
      pn_q   <= pn_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_tx_line_encoder.sv
// USB full-speed transmit line encoder: SYNC, LSb-first serialisation of the
// packet bytes at 12 Mbit/s, bit stuffing, NRZI and EOP onto the D+/D- pair.
module usb_tx_line_encoder
  import sie_defs_pkg::*;
#(
  parameter int         CLK_PER_BIT  = 4,
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LEN    = 6
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       usbResetDetect,
  input  logic       reqSendPacket,
  input  logic       txDataValid,
  input  logic       txIsLastByte,
  input  logic [7:0] txData,
  output logic       txAcceptNewData,
  output logic       sending,
  output logic       txUnderrun,
  output logic       outEN,
  output logic       dataOutP,
  output logic       dataOutN
);

  localparam int               CNT_W    = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       buf_q, buf_d;
  logic             shift_last_q, shift_last_d;
  logic             buf_last_q, buf_last_d;
  logic             buf_full_q, buf_full_d;
  logic             accept_q, accept_d;
  logic             underrun_q, underrun_d;
  logic             outen_q, outen_d;
  logic             sending_q, sending_d;

  logic             wr_s, bit_end_s, end_of_pkt_s;
  logic             enc_strobe_s, enc_bit_s, enc_stuff_s;
  logic [1:0]       enc_cmd_s;
  logic [7:0]       next_byte_s;

  usb_nrzi_stuff_enc #(
    .STUFF_LEN(STUFF_LEN)
  ) u_enc (
    .clk48        (clk48),
    .rst_n        (rst_n),
    .strobe       (enc_strobe_s),
    .cmd          (enc_cmd_s),
    .bit_in       (enc_bit_s),
    .stuff_pending(enc_stuff_s),
    .dataOutP     (dataOutP),
    .dataOutN     (dataOutN)
  );

  assign txAcceptNewData = accept_q;
  assign sending         = sending_q;
  assign txUnderrun      = underrun_q;
  assign outEN           = outen_q;

  // FSM, bit timer, holding buffer and shift register next-state
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    buf_d        = buf_q;
    buf_last_d   = buf_last_q;
    buf_full_d   = buf_full_q;
    outen_d      = outen_q;
    sending_d    = sending_q;
    underrun_d   = 1'b0;
    enc_strobe_s = 1'b0;
    enc_cmd_s    = ENC_DATA;
    enc_bit_s    = 1'b0;
    wr_s         = txDataValid & accept_q;
    bit_end_s    = (cnt_q == CNT_LAST);
    end_of_pkt_s = (state_q == TX_DATA) && shift_last_q;
    // An empty buffer can still be refilled straight from the bus in the boundary cycle
    next_byte_s  = buf_full_q ? buf_q : txData;

    if (wr_s) begin
      buf_d      = txData;
      buf_last_d = txIsLastByte;
      buf_full_d = 1'b1;
    end else begin
      buf_d = buf_q;
    end

    if (state_q == TX_IDLE) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (usbResetDetect) begin
      state_d      = TX_IDLE;
      cnt_d        = {CNT_W{1'b0}};
      bit_cnt_d    = 3'd0;
      outen_d      = 1'b0;
      sending_d    = 1'b0;
      buf_full_d   = 1'b0;
      buf_last_d   = 1'b0;
      enc_strobe_s = 1'b1;
      enc_cmd_s    = ENC_J;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (reqSendPacket) begin
            state_d      = TX_SYNC;
            bit_cnt_d    = 3'd0;
            outen_d      = 1'b1;
            sending_d    = 1'b1;
            enc_strobe_s = 1'b1;
            enc_bit_s    = SYNC_PATTERN[0];
          end else begin
            state_d = TX_IDLE;
          end
        end
        TX_SYNC, TX_DATA: begin
          if (bit_end_s) begin
            enc_strobe_s = 1'b1;
            if (enc_stuff_s) begin
              // Encoder inserts the stuffed 0; the data stream holds for this bit
              bit_cnt_d = bit_cnt_q;
            end else if (bit_cnt_q != 3'd7) begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              shift_d   = {1'b0, shift_q[6:1]};
              enc_bit_s = (state_q == TX_SYNC) ? SYNC_PATTERN[bit_cnt_d] : shift_q[0];
            end else if (end_of_pkt_s || !(buf_full_q || wr_s)) begin
              underrun_d = !end_of_pkt_s;
              state_d    = TX_EOP_SE0;
              bit_cnt_d  = 3'd0;
              buf_full_d = 1'b0;
              enc_cmd_s  = ENC_SE0;
            end else begin
              state_d      = TX_DATA;
              bit_cnt_d    = 3'd0;
              buf_full_d   = 1'b0;
              shift_d      = next_byte_s[7:1];
              shift_last_d = buf_full_q ? buf_last_q : txIsLastByte;
              enc_bit_s    = next_byte_s[0];
            end
          end else begin
            state_d = state_q;
          end
        end
        TX_EOP_SE0: begin
          buf_full_d = 1'b0;
          if (bit_end_s) begin
            enc_strobe_s = 1'b1;
            if (bit_cnt_q == 3'd0) begin
              bit_cnt_d = 3'd1;
              enc_cmd_s = ENC_SE0;
            end else begin
              state_d   = TX_EOP_J;
              enc_cmd_s = ENC_J;
            end
          end else begin
            state_d = state_q;
          end
        end
        TX_EOP_J: begin
          buf_full_d = 1'b0;
          if (bit_end_s) begin
            state_d   = TX_IDLE;
            outen_d   = 1'b0;
            sending_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d    = TX_IDLE;
          outen_d    = 1'b0;
          sending_d  = 1'b0;
          buf_full_d = 1'b0;
        end
      endcase
    end

    accept_d = !buf_full_d && ((state_d == TX_SYNC) || (state_d == TX_DATA));
  end

  // State and datapath registers
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TX_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      shift_last_q <= 1'b0;
      buf_q        <= 8'd0;
      buf_last_q   <= 1'b0;
      buf_full_q   <= 1'b0;
      accept_q     <= 1'b0;
      underrun_q   <= 1'b0;
      outen_q      <= 1'b0;
      sending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      buf_q        <= buf_d;
      buf_last_q   <= buf_last_d;
      buf_full_q   <= buf_full_d;
      accept_q     <= accept_d;
      underrun_q   <= underrun_d;
      outen_q      <= outen_d;
      sending_q    <= sending_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_line_encoder.sv
// Self-checking bench for usb_tx_line_encoder: directed and random packets
// compared bit-time by bit-time against a behavioural line model.
`timescale 1ns/1ps
module tb_usb_tx_line_encoder;

  logic       clk48;
  logic       rst_n;
  logic       usbResetDetect;
  logic       reqSendPacket;
  logic       txDataValid;
  logic       txIsLastByte;
  logic [7:0] txData;
  logic       txAcceptNewData;
  logic       sending;
  logic       txUnderrun;
  logic       outEN;
  logic       dataOutP;
  logic       dataOutN;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] pkt [0:3];
  logic [1:0] exp_q [$];

  usb_tx_line_encoder dut (
    .clk48          (clk48),
    .rst_n          (rst_n),
    .usbResetDetect (usbResetDetect),
    .reqSendPacket  (reqSendPacket),
    .txDataValid    (txDataValid),
    .txIsLastByte   (txIsLastByte),
    .txData         (txData),
    .txAcceptNewData(txAcceptNewData),
    .sending        (sending),
    .txUnderrun     (txUnderrun),
    .outEN          (outEN),
    .dataOutP       (dataOutP),
    .dataOutN       (dataOutN)
  );

  initial clk48 = 1'b0;
  always #10 clk48 = ~clk48;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line levels ({P,N}) per bit time: SYNC + nb bytes, stuffing, NRZI, EOP
  function automatic void build_expected(input int nb);
    logic [1:0] lvl;
    logic [7:0] sync_b;
    logic [7:0] cur;
    logic       b;
    int         ones;
    sync_b = 8'h80;
    lvl    = 2'b10;
    ones   = 0;
    exp_q.delete();
    for (int i = 0; i < 8 * (nb + 1); i++) begin
      if (i < 8) cur = sync_b;
      else       cur = pkt[(i / 8) - 1];
      b = cur[i % 8];
      if (b == 1'b0) begin
        lvl  = ~lvl;
        ones = 0;
      end else begin
        ones++;
      end
      exp_q.push_back(lvl);
      if (ones == 6) begin
        lvl  = ~lvl;
        ones = 0;
        exp_q.push_back(lvl);
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endfunction

  // Sends pkt[0..n-1] (only pkt[0], never marked last, when underrun_mode) and checks the line
  task automatic run_pkt(input string tag, input int n, input bit underrun_mode, output int en_out);
    logic [1:0] obs [$];
    int  idx, cyc, lat, en_cyc, under_cnt;
    bit  seen_en, done;
    build_expected(underrun_mode ? 1 : n);
    idx = 0; cyc = 0; lat = -1; en_cyc = 0; under_cnt = 0; seen_en = 1'b0; done = 1'b0;
    reqSendPacket = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk48);
      cyc++;
      reqSendPacket = 1'b0;
      if (txUnderrun === 1'b1) under_cnt++;
      chk({tag, ".sending_eq_outen"}, {31'd0, sending}, {31'd0, outEN});
      if (outEN === 1'b1) begin
        if (!seen_en) begin
          lat = cyc;
          chk({tag, ".first_accept"}, {31'd0, txAcceptNewData}, 32'd1);
        end
        seen_en = 1'b1;
        en_cyc++;
        obs.push_back({dataOutP, dataOutN});
      end else if (seen_en) begin
        done = 1'b1;
      end
      if (idx < n && !(underrun_mode && idx >= 1)) begin
        txDataValid  = 1'b1;
        txData       = pkt[idx];
        txIsLastByte = !underrun_mode && (idx == n - 1);
        if (txAcceptNewData === 1'b1) idx++;
      end else begin
        txDataValid  = 1'b0;
        txIsLastByte = 1'b0;
        txData       = 8'h00;
      end
    end
    chk({tag, ".completed"}, {31'd0, done}, 32'd1);
    chk({tag, ".start_latency"}, lat, 32'd1);
    chk({tag, ".en_cycles"}, en_cyc, 4 * exp_q.size());
    chk({tag, ".underrun_pulses"}, under_cnt, underrun_mode ? 32'd1 : 32'd0);
    chk({tag, ".idle_line"}, {30'd0, dataOutP, dataOutN}, 32'h2);
    chk({tag, ".idle_accept"}, {31'd0, txAcceptNewData}, 32'd0);
    for (int i = 0; i < obs.size(); i++) begin
      if (i / 4 < exp_q.size()) chk($sformatf("%s.line[%0d]", tag, i / 4), {30'd0, obs[i]}, {30'd0, exp_q[i / 4]});
    end
    en_out = en_cyc;
  endtask

  initial begin
    int en;
    int idx;
    rst_n = 1'b0; usbResetDetect = 1'b0; reqSendPacket = 1'b0;
    txDataValid = 1'b0; txIsLastByte = 1'b0; txData = 8'h00;
    repeat (3) @(negedge clk48);
    rst_n = 1'b1;
    @(negedge clk48);
    chk("reset.outEN", {31'd0, outEN}, 32'd0);
    chk("reset.sending", {31'd0, sending}, 32'd0);
    chk("reset.accept", {31'd0, txAcceptNewData}, 32'd0);
    chk("reset.underrun", {31'd0, txUnderrun}, 32'd0);
    chk("reset.line", {30'd0, dataOutP, dataOutN}, 32'h2);

    // ACK handshake packet
    pkt[0] = 8'hD2;
    run_pkt("ack", 1, 1'b0, en);
    chk("ack.total", en, 32'd76);

    // Stuffing across bytes, with SYNC's trailing 1 counted
    repeat (2) @(negedge clk48);
    pkt[0] = 8'hFF; pkt[1] = 8'hFF;
    run_pkt("stuff", 2, 1'b0, en);
    chk("stuff.total", en, 32'd116);

    // Stuff bit owed after the final data bit
    pkt[0] = 8'hFC;
    run_pkt("trail", 1, 1'b0, en);
    chk("trail.total", en, 32'd80);

    // Underrun after a non-last byte
    pkt[0] = 8'h4B;
    run_pkt("underrun", 1, 1'b1, en);
    chk("underrun.total", en, 32'd76);

    // Bus reset mid-byte with a second byte parked in the holding buffer
    @(negedge clk48);
    pkt[0] = 8'hA5; pkt[1] = 8'h3C;
    idx = 0;
    reqSendPacket = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk48);
      reqSendPacket = 1'b0;
      if (idx < 2) begin
        txDataValid = 1'b1; txData = pkt[idx]; txIsLastByte = (idx == 1);
        if (txAcceptNewData === 1'b1) idx++;
      end else begin
        txDataValid = 1'b0; txIsLastByte = 1'b0;
      end
    end
    txDataValid = 1'b0; txIsLastByte = 1'b0;
    chk("busrst.bytes_taken", idx, 32'd2);
    chk("busrst.pre_outEN", {31'd0, outEN}, 32'd1);
    usbResetDetect = 1'b1;
    reqSendPacket  = 1'b1;
    @(negedge clk48);
    usbResetDetect = 1'b0;
    reqSendPacket  = 1'b0;
    chk("busrst.outEN", {31'd0, outEN}, 32'd0);
    chk("busrst.sending", {31'd0, sending}, 32'd0);
    chk("busrst.line", {30'd0, dataOutP, dataOutN}, 32'h2);
    chk("busrst.accept", {31'd0, txAcceptNewData}, 32'd0);
    repeat (2) @(negedge clk48);
    chk("busrst.still_idle", {31'd0, outEN}, 32'd0);
    pkt[0] = 8'hD2;
    run_pkt("after_busrst", 1, 1'b0, en);
    chk("after_busrst.total", en, 32'd76);

    // Asynchronous reset in the middle of SYNC
    reqSendPacket = 1'b1;
    @(negedge clk48);
    reqSendPacket = 1'b0;
    repeat (10) @(negedge clk48);
    chk("arst.pre_outEN", {31'd0, outEN}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.outEN", {31'd0, outEN}, 32'd0);
    chk("arst.sending", {31'd0, sending}, 32'd0);
    chk("arst.accept", {31'd0, txAcceptNewData}, 32'd0);
    chk("arst.line", {30'd0, dataOutP, dataOutN}, 32'h2);
    @(negedge clk48);
    rst_n = 1'b1;
    @(negedge clk48);
    pkt[0] = 8'hD2;
    run_pkt("b2b_0", 1, 1'b0, en);
    chk("b2b_0.total", en, 32'd76);
    run_pkt("b2b_1", 1, 1'b0, en);
    chk("b2b_1.total", en, 32'd76);

    // Random packets, biased toward long runs of 1s
    for (int p = 0; p < 8; p++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 2) == 0) pkt[i] = 8'hFF;
        else                           pkt[i] = 8'($urandom);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk48);
      run_pkt($sformatf("rand%0d", p), n, 1'b0, en);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
